// File: rtl/text_term_ctrl_if.sv
// Keyboard byte handshake and character-RAM write port of the terminal controller.
// Latency: wires only.
// Backpressure: kb_data/kb_valid held by the source until kb_ready; writes are never stalled.
interface text_term_ctrl_if #(
  parameter int ADDR_W = 12
) ();
  logic [7:0]        kb_data;
  logic              kb_valid;
  logic              kb_ready;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [7:0]        wr_data;

  // Controller side: consumes scan codes, drives the character RAM.
  modport master (
    input  kb_data, kb_valid,
    output kb_ready, wr_en, wr_addr, wr_data
  );

  // Environment side: keyboard receiver and RAM/observer.
  modport slave (
    output kb_data, kb_valid,
    input  kb_ready, wr_en, wr_addr, wr_data
  );
endinterface

// File: rtl/text_term_ctrl.sv
// PS/2 set-2 scan codes to ASCII writes into a COLS x ROWS character RAM at a cursor.
// Latency: a write lands in the cycle after the byte transfer; cursor moves the cycle after that.
// Backpressure: kb_ready only in IDLE, so at most one byte per 2 cycles; low for the whole of a clear.
module text_term_ctrl #(
  parameter int COLS   = 70,
  parameter int ROWS   = 30,
  parameter int ADDR_W = 12
) (
  input  logic             clk,
  input  logic             rst,
  text_term_ctrl_if.master bus,
  output logic [4:0]       cur_row,
  output logic [6:0]       cur_col,
  output logic [7:0]       key_count,
  output logic             busy
);

  typedef enum logic [1:0] {CLR_ALL, IDLE, EXEC, CLR_ROW} state_t;
  typedef enum logic [2:0] {
    ACT_NONE, ACT_BREAK, ACT_SHIFT, ACT_REL, ACT_PRINT, ACT_ENTER, ACT_BS
  } act_t;

  localparam logic [ADDR_W-1:0] CELLS    = ADDR_W'(COLS * ROWS);
  localparam logic [ADDR_W-1:0] ROW_LEN  = ADDR_W'(COLS);
  localparam logic [6:0]        LAST_COL = 7'(COLS - 1);
  localparam logic [4:0]        LAST_ROW = 5'(ROWS - 1);

  state_t            state;
  act_t              act_q;
  act_t              act;
  logic              break_flag;
  logic              shift;
  logic [ADDR_W-1:0] clr_cnt;
  logic [7:0]        ascii;
  logic [4:0]        next_row;
  logic [ADDR_W-1:0] row_base;
  logic [ADDR_W-1:0] next_base;
  logic [ADDR_W-1:0] cell_addr;
  logic              wrap_row;

  // Decode the incoming byte against the current break/shift state and cursor.
  always_comb begin
    ascii = 8'h00;
    case (bus.kb_data)
      8'h1C: ascii = 8'h61; 8'h32: ascii = 8'h62; 8'h21: ascii = 8'h63;
      8'h23: ascii = 8'h64; 8'h24: ascii = 8'h65; 8'h2B: ascii = 8'h66;
      8'h34: ascii = 8'h67; 8'h33: ascii = 8'h68; 8'h43: ascii = 8'h69;
      8'h3B: ascii = 8'h6A; 8'h42: ascii = 8'h6B; 8'h4B: ascii = 8'h6C;
      8'h3A: ascii = 8'h6D; 8'h31: ascii = 8'h6E; 8'h44: ascii = 8'h6F;
      8'h4D: ascii = 8'h70; 8'h15: ascii = 8'h71; 8'h2D: ascii = 8'h72;
      8'h1B: ascii = 8'h73; 8'h2C: ascii = 8'h74; 8'h3C: ascii = 8'h75;
      8'h2A: ascii = 8'h76; 8'h1D: ascii = 8'h77; 8'h22: ascii = 8'h78;
      8'h35: ascii = 8'h79; 8'h1A: ascii = 8'h7A;
      8'h45: ascii = 8'h30; 8'h16: ascii = 8'h31; 8'h1E: ascii = 8'h32;
      8'h26: ascii = 8'h33; 8'h25: ascii = 8'h34; 8'h2E: ascii = 8'h35;
      8'h36: ascii = 8'h36; 8'h3D: ascii = 8'h37; 8'h3E: ascii = 8'h38;
      8'h46: ascii = 8'h39; 8'h29: ascii = 8'h20;
      default: ascii = 8'h00;
    endcase
    // Only letters have bit 6 set; clearing bit 5 gives the uppercase form.
    if (ascii[6] && shift) ascii = ascii & 8'hDF;

    act = ACT_NONE;
    if (bus.kb_data == 8'hF0)                              act = ACT_BREAK;
    else if (bus.kb_data == 8'hE0)                         act = ACT_NONE;
    else if (bus.kb_data == 8'h12 || bus.kb_data == 8'h59) act = ACT_SHIFT;
    else if (break_flag)                                   act = ACT_REL;
    else if (ascii != 8'h00)                               act = ACT_PRINT;
    else if (bus.kb_data == 8'h5A)                         act = ACT_ENTER;
    else if (bus.kb_data == 8'h66)                         act = ACT_BS;

    next_row  = (cur_row == LAST_ROW) ? 5'd0 : cur_row + 5'd1;
    row_base  = ADDR_W'(cur_row) * ROW_LEN;
    next_base = ADDR_W'(next_row) * ROW_LEN;
    cell_addr = row_base + ADDR_W'(cur_col);
    wrap_row  = (act_q == ACT_ENTER) || (act_q == ACT_PRINT && cur_col == LAST_COL);
  end

  // Controller FSM with all outputs registered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= CLR_ALL;
      act_q        <= ACT_NONE;
      bus.wr_en    <= 1'b0;
      bus.wr_addr  <= '0;
      bus.wr_data  <= 8'h20;
      bus.kb_ready <= 1'b0;
      cur_row      <= 5'd0;
      cur_col      <= 7'd0;
      key_count    <= 8'd0;
      busy         <= 1'b1;
      break_flag   <= 1'b0;
      shift        <= 1'b0;
      clr_cnt      <= '0;
    end else begin
      case (state)
        CLR_ALL: begin
          if (clr_cnt < CELLS) begin
            bus.wr_en   <= 1'b1;
            bus.wr_addr <= clr_cnt;
            bus.wr_data <= 8'h20;
            clr_cnt     <= clr_cnt + ADDR_W'(1);
          end else begin
            bus.wr_en    <= 1'b0;
            cur_row      <= 5'd0;
            cur_col      <= 7'd0;
            busy         <= 1'b0;
            bus.kb_ready <= 1'b1;
            state        <= IDLE;
          end
        end

        IDLE: begin
          if (bus.kb_valid && bus.kb_ready) begin
            bus.kb_ready <= 1'b0;
            act_q        <= act;
            state        <= EXEC;
            // The write is issued here so it occupies the EXEC cycle itself.
            if (act == ACT_PRINT) begin
              bus.wr_en   <= 1'b1;
              bus.wr_addr <= cell_addr;
              bus.wr_data <= ascii;
            end else if (act == ACT_BS && (cur_row != 5'd0 || cur_col != 7'd0)) begin
              // Left one cell, or end of previous row: both are linear address - 1.
              bus.wr_en   <= 1'b1;
              bus.wr_addr <= cell_addr - ADDR_W'(1);
              bus.wr_data <= 8'h20;
            end
          end
        end

        EXEC: begin
          bus.wr_en    <= 1'b0;
          bus.kb_ready <= 1'b1;
          state        <= IDLE;
          case (act_q)
            ACT_BREAK: break_flag <= 1'b1;
            ACT_SHIFT: begin
              shift      <= ~break_flag;
              break_flag <= 1'b0;
            end
            ACT_REL:   break_flag <= 1'b0;
            ACT_PRINT: begin
              key_count <= key_count + 8'd1;
              cur_col   <= (cur_col == LAST_COL) ? 7'd0 : cur_col + 7'd1;
            end
            ACT_BS: begin
              if (cur_col != 7'd0) begin
                cur_col <= cur_col - 7'd1;
              end else if (cur_row != 5'd0) begin
                cur_row <= cur_row - 5'd1;
                cur_col <= LAST_COL;
              end
            end
            default: ;
          endcase
          // Moving onto a new row blanks it; first cell goes out right away.
          if (wrap_row) begin
            cur_col      <= 7'd0;
            cur_row      <= next_row;
            bus.kb_ready <= 1'b0;
            busy         <= 1'b1;
            bus.wr_en    <= 1'b1;
            bus.wr_addr  <= next_base;
            bus.wr_data  <= 8'h20;
            clr_cnt      <= ADDR_W'(1);
            state        <= CLR_ROW;
          end
        end

        CLR_ROW: begin
          if (clr_cnt < ROW_LEN) begin
            bus.wr_en   <= 1'b1;
            bus.wr_addr <= row_base + clr_cnt;
            clr_cnt     <= clr_cnt + ADDR_W'(1);
          end else begin
            bus.wr_en    <= 1'b0;
            busy         <= 1'b0;
            bus.kb_ready <= 1'b1;
            state        <= IDLE;
          end
        end

        default: state <= CLR_ALL;
      endcase
    end
  end

endmodule

// File: tb/tb_text_term_ctrl.sv
// Directed bench for text_term_ctrl: scoreboard of expected RAM writes plus cursor/timing checks.
// Latency: n/a.
// Backpressure: bytes are offered only after kb_ready is seen high.
module tb_text_term_ctrl;

  typedef struct packed {
    logic [11:0] addr;
    logic [7:0]  data;
  } wr_t;

  logic clk;
  logic rst;
  logic [4:0] cur_row;
  logic [6:0] cur_col;
  logic [7:0] key_count;
  logic busy;

  int checks = 0;
  int errors = 0;
  wr_t sb[$];
  wr_t mon_exp;

  text_term_ctrl_if #(.ADDR_W(12)) bus ();

  text_term_ctrl #(.COLS(70), .ROWS(30), .ADDR_W(12)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .cur_row   (cur_row),
    .cur_col   (cur_col),
    .key_count (key_count),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Every RAM write must match the head of the scoreboard.
  always @(negedge clk) begin
    if (!rst && bus.wr_en === 1'b1) begin
      checks++;
      assert (sb.size() != 0) else begin
        errors++;
        $error("FAIL unexpected_write: addr %0d data %02h, expected no write", bus.wr_addr, bus.wr_data);
      end
      if (sb.size() != 0) begin
        mon_exp = sb.pop_front();
        checks++;
        assert ({bus.wr_addr, bus.wr_data} === {mon_exp.addr, mon_exp.data}) else begin
          errors++;
          $error("FAIL write: observed addr %0d data %02h, expected addr %0d data %02h",
                 bus.wr_addr, bus.wr_data, mon_exp.addr, mon_exp.data);
        end
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic push(input int addr, input logic [7:0] data);
    wr_t e;
    e.addr = 12'(addr);
    e.data = data;
    sb.push_back(e);
  endtask

  task automatic wait_ready(output int n);
    n = 0;
    while (bus.kb_ready !== 1'b1 && n < 5000) begin
      @(negedge clk);
      n++;
    end
    check("ready_timeout", 32'(bus.kb_ready), 32'd1);
  endtask

  task automatic send(input logic [7:0] b);
    int n;
    wait_ready(n);
    bus.kb_data  = b;
    bus.kb_valid = 1'b1;
    @(negedge clk);
    bus.kb_valid = 1'b0;
  endtask

  task automatic check_cursor(input string tag, input int row, input int col, input int kc);
    check({tag, "_row"}, 32'(cur_row), 32'(row));
    check({tag, "_col"}, 32'(cur_col), 32'(col));
    check({tag, "_keys"}, 32'(key_count), 32'(kc));
    check({tag, "_sb_empty"}, 32'(sb.size()), 32'd0);
  endtask

  // Pulse reset, check reset values, then expect a full ascending blanking pass.
  task automatic do_reset();
    int n;
    int wc;
    rst = 1'b1;
    bus.kb_valid = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_wr_en", 32'(bus.wr_en), 32'd0);
    check("rst_wr_addr", 32'(bus.wr_addr), 32'd0);
    check("rst_wr_data", 32'(bus.wr_data), 32'h20);
    check("rst_kb_ready", 32'(bus.kb_ready), 32'd0);
    check("rst_busy", 32'(busy), 32'd1);
    check("rst_row", 32'(cur_row), 32'd0);
    check("rst_col", 32'(cur_col), 32'd0);
    check("rst_keys", 32'(key_count), 32'd0);
    sb.delete();
    for (int i = 0; i < 2100; i++) push(i, 8'h20);
    rst = 1'b0;
    n = 0;
    wc = 0;
    do begin
      @(negedge clk);
      n++;
      if (bus.wr_en === 1'b1) wc++;
    end while (bus.kb_ready !== 1'b1 && n < 3000);
    check("clr_all_ready_cycle", 32'(n), 32'd2101);
    check("clr_all_writes", 32'(wc), 32'd2100);
    check("clr_all_busy_done", 32'(busy), 32'd0);
    check_cursor("clr_all", 0, 0, 0);
  endtask

  initial begin
    int n;
    int wc;
    rst = 1'b1;
    bus.kb_valid = 1'b0;
    bus.kb_data = 8'h00;

    do_reset();

    // Backspace at home does nothing.
    send(8'h66);
    wait_ready(n);
    check_cursor("bs_home", 0, 0, 0);

    // 'a' make: write lands the next cycle, cursor one later.
    push(0, 8'h61);
    send(8'h1C);
    check("a_wr_en_exec", 32'(bus.wr_en), 32'd1);
    check("a_ready_exec", 32'(bus.kb_ready), 32'd0);
    check("a_col_not_yet", 32'(cur_col), 32'd0);
    @(negedge clk);
    check("a_wr_en_off", 32'(bus.wr_en), 32'd0);
    check("a_ready_back", 32'(bus.kb_ready), 32'd1);
    check("a_wr_addr_hold", 32'(bus.wr_addr), 32'd0);
    check("a_wr_data_hold", 32'(bus.wr_data), 32'h61);
    send(8'hF0);
    send(8'h1C);
    wait_ready(n);
    check_cursor("a_release", 0, 1, 1);

    // Extended prefix and unlisted make code are ignored.
    send(8'hE0);
    send(8'h76);
    wait_ready(n);
    check_cursor("ignored", 0, 1, 1);

    // Shifted letter, released shift, shifted digit.
    do_reset();
    push(0, 8'h42);
    push(1, 8'h62);
    push(2, 8'h31);
    send(8'h12);
    send(8'h32);
    send(8'hF0);
    send(8'h12);
    send(8'h32);
    send(8'h59);
    send(8'h16);
    send(8'hF0);
    send(8'h59);
    wait_ready(n);
    check_cursor("shift", 0, 3, 3);

    // Fill row 0 with '1': wrap to row 1 and blank it.
    do_reset();
    for (int i = 0; i < 70; i++) push(i, 8'h31);
    for (int i = 0; i < 70; i++) push(70 + i, 8'h20);
    for (int i = 0; i < 69; i++) send(8'h16);
    send(8'h16);
    check("wrap_exec_write", 32'(bus.wr_en), 32'd1);
    n = 0;
    wc = 0;
    do begin
      @(negedge clk);
      n++;
      if (bus.wr_en === 1'b1) wc++;
      if (n == 1) check("wrap_busy", 32'(busy), 32'd1);
    end while (bus.kb_ready !== 1'b1 && n < 200);
    check("wrap_ready_cycle", 32'(n), 32'd71);
    check("wrap_clear_writes", 32'(wc), 32'd70);
    check_cursor("wrap", 1, 0, 70);

    // Backspace from column 0 goes to the end of the previous row.
    push(69, 8'h20);
    send(8'h66);
    wait_ready(n);
    check_cursor("bs_prev_row", 0, 69, 70);

    // Enter down to row 29, type 5 spaces, Enter wraps to row 0.
    for (int r = 0; r < 29; r++) begin
      for (int c = 0; c < 70; c++) push((r + 1) * 70 + c, 8'h20);
      send(8'h5A);
    end
    wait_ready(n);
    check_cursor("enter_29", 29, 0, 70);
    for (int i = 0; i < 5; i++) begin
      push(2030 + i, 8'h20);
      send(8'h29);
    end
    wait_ready(n);
    check_cursor("spaces", 29, 5, 75);
    for (int c = 0; c < 70; c++) push(c, 8'h20);
    send(8'h5A);
    wait_ready(n);
    check_cursor("enter_wrap", 0, 0, 75);

    // Reset in the middle of a row clear aborts it and restarts the full clear.
    push(0, 8'h7A);
    send(8'h1A);
    for (int c = 0; c < 10; c++) push(70 + c, 8'h20);
    send(8'h5A);
    repeat (10) @(negedge clk);
    check("midclr_busy", 32'(busy), 32'd1);
    check("midclr_keys", 32'(key_count), 32'd76);
    do_reset();

    repeat (3) @(negedge clk);
    check("final_sb_empty", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
